// File: rtl/snn_output_spike_fifo_pkg.sv
// Shared interface definitions for the SNN output spike path.
//   OUTPUT_FIFO_DATA_WIDTH    : packed width of output_vector_t (17 bits)
//   DEFAULT_OUTPUT_FIFO_DEPTH : default number of entries in the output spike FIFO
//   output_vector_t           : {timestep, x[6:0], y[6:0], spikes[1:0]}
//   pack_output_vector        : builds an output_vector_t from its fields
//   is_zero_spike_vector      : true when a vector has no spikes and no timestep marker
package snn_output_spike_fifo_pkg;

    localparam int unsigned OUTPUT_FIFO_DATA_WIDTH    = 17;
    localparam int unsigned DEFAULT_OUTPUT_FIFO_DEPTH = 64;

    typedef struct packed {
        logic       timestep;
        logic [6:0] x;
        logic [6:0] y;
        logic [1:0] spikes;
    } output_vector_t;

    function automatic output_vector_t pack_output_vector(
        input logic       timestep,
        input logic [6:0] x,
        input logic [6:0] y,
        input logic [1:0] spikes
    );
        output_vector_t v;
        v.timestep = timestep;
        v.x        = x;
        v.y        = y;
        v.spikes   = spikes;
        return v;
    endfunction

    function automatic logic is_zero_spike_vector(input output_vector_t v);
        return (v.spikes == '0) && !v.timestep;
    endfunction

endpackage

// File: rtl/snn_output_spike_fifo.sv
// Output spike FIFO: buffers packed output vectors between the pooling/threshold stage and the
// downstream consumer. First-word-fall-through, no write bypass, synchronous flush.
//
// Optional feature (macro SNN_OUTPUT_ZERO_FILTER_EN): vectors with no spikes and no timestep
// marker complete their handshake but are dropped instead of stored.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (pointers and count)
//   clear      : synchronous flush, beats accept and pop in the same cycle
//   in_valid   : upstream vector present
//   in_ready   : FIFO can accept (count != DEPTH)
//   in_data    : packed output_vector_t
//   out_valid  : head entry present (count != 0)
//   out_ready  : downstream accepts head entry
//   out_data   : head entry (combinational read of storage)
//   fill_level : number of stored entries
module snn_output_spike_fifo
    import snn_output_spike_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_OUTPUT_FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH = OUTPUT_FIFO_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]    fill_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic accept;
    logic pop;
    logic store;

    assign in_ready   = (count_q != FullCount);
    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign fill_level = count_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

`ifdef SNN_OUTPUT_ZERO_FILTER_EN
    // Zero vectors are consumed upstream-side but never occupy an entry.
    assign store = accept && !clear && !is_zero_spike_vector(output_vector_t'(in_data));
`else
    assign store = accept && !clear;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset or flushed; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_snn_output_spike_fifo.sv
module tb_snn_output_spike_fifo;

    localparam int DEPTH = 64;
    localparam int DW    = 17;
`ifdef SNN_OUTPUT_ZERO_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [6:0]    fill_level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q[$];

    always #5 clk = ~clk;

    snn_output_spike_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill_level (fill_level)
    );

    function automatic logic [DW-1:0] mk(input bit ts, input int x, input int y, input int sp);
        logic [DW-1:0] w;
        w = {ts, 7'(x), 7'(y), 2'(sp)};
        return w;
    endfunction

    function automatic bit is_zero(input logic [DW-1:0] w);
        return (w[1:0] == 2'b00) && (w[16] == 1'b0);
    endfunction

    // Drive one cycle of stimulus, advance the reference queue by the FIFO rules, then move to
    // #1 after the rising edge so outputs can be sampled.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
        bit acc;
        bit pp;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        acc = v && (model_q.size() < DEPTH);
        pp  = r && (model_q.size() > 0);
        if (c) begin
            model_q.delete();
        end else begin
            if (pp) void'(model_q.pop_front());
            if (acc && !(FILT && is_zero(d))) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fill_level !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b fill=%0d, want rdy=1 vld=0 fill=0",
                     in_ready, out_valid, fill_level);
        end
        do_reset();
        n_checks++;
        if (in_ready !== 1'b1 || fill_level !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b fill=%0d, want rdy=1 fill=0",
                     in_ready, fill_level);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        w = mk(1'b0, 5, 3, 1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: got out_valid=%b, want 0", out_valid);
        end
        step(1'b1, w, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 17'h00a0d || fill_level !== 7'd1) begin
            n_fail++;
            $display("FAIL single_write: got vld=%b data=%h fill=%0d, want vld=1 data=00a0d fill=1",
                     out_valid, out_data, fill_level);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || fill_level !== 7'd0) begin
            n_fail++;
            $display("FAIL single_read: got vld=%b fill=%0d, want vld=0 fill=0",
                     out_valid, fill_level);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] words[DEPTH];
        int errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            // x carries the index so every word is distinct; spikes nonzero so the filter keeps it
            words[i] = mk(1'($urandom_range(1)), i, $urandom_range(127), $urandom_range(3, 1));
            step(1'b1, words[i], 1'b0, 1'b0);
        end
        n_checks++;
        if (in_ready !== 1'b0 || fill_level !== 7'd64) begin
            n_fail++;
            $display("FAIL fill_full: got rdy=%b fill=%0d, want rdy=0 fill=64", in_ready, fill_level);
        end
        step(1'b1, mk(1'b1, 100, 100, 3), 1'b0, 1'b0);
        n_checks++;
        if (fill_level !== 7'd64 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_reject: got fill=%0d rdy=%b, want fill=64 rdy=0", fill_level, in_ready);
        end
        // Pop while full and offer a word in the same cycle: no write-through.
        for (int i = 0; i < DEPTH; i++) begin
            if (out_valid !== 1'b1 || out_data !== words[i]) errs++;
            step(i == 0, mk(1'b1, 101, 101, 3), 1'b1, 1'b0);
        end
        n_checks++;
        if (errs != 0 || fill_level !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drain: got %0d order errors fill=%0d vld=%b, want 0 errors fill=0 vld=0",
                     errs, fill_level, out_valid);
        end
    endtask

    task automatic test_simul();
        int errs = 0;
        for (int i = 0; i < 10; i++) step(1'b1, mk(1'b0, i, 7, 2), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (out_data !== model_q[0] || fill_level !== 7'd10) errs++;
            step(1'b1, mk(1'($urandom_range(1)), $urandom_range(127), i, $urandom_range(3, 1)),
                 1'b1, 1'b0);
        end
        n_checks++;
        if (errs != 0 || fill_level !== 7'd10) begin
            n_fail++;
            $display("FAIL simul_push_pop: got %0d errors fill=%0d, want 0 errors fill=10",
                     errs, fill_level);
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        logic [DW-1:0] fresh;
        for (int i = 0; i < 7; i++) step(1'b1, mk(1'b0, i, 9, 1), 1'b0, 1'b0);
        n_checks++;
        if (fill_level !== 7'd7) begin
            n_fail++;
            $display("FAIL clear_setup: got fill=%0d, want 7", fill_level);
        end
        step(1'b1, mk(1'b1, 77, 77, 3), 1'b1, 1'b1);
        n_checks++;
        if (fill_level !== 7'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_priority: got fill=%0d vld=%b rdy=%b, want fill=0 vld=0 rdy=1",
                     fill_level, out_valid, in_ready);
        end
        fresh = mk(1'b0, 12, 34, 2);
        step(1'b1, fresh, 1'b0, 1'b0);
        idle();
        n_checks++;
        if (out_data !== fresh || fill_level !== 7'd1) begin
            n_fail++;
            $display("FAIL clear_discard: got data=%h fill=%0d, want data=%h fill=1",
                     out_data, fill_level, fresh);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20; i++) step(1'b1, mk(1'b0, i, 1, 3), 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || fill_level !== 7'd20) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got vld=%b fill=%0d, want vld=1 fill=20",
                     out_valid, fill_level);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fill_level !== 7'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got vld=%b fill=%0d rdy=%b, want vld=0 fill=0 rdy=1",
                     out_valid, fill_level, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_filter();
        logic [DW-1:0] w[3];
        int hs = 0;
        w[0] = mk(1'b0, 4, 4, 0);
        w[1] = mk(1'b1, 4, 4, 0);
        w[2] = mk(1'b0, 4, 4, 2);
        for (int i = 0; i < 3; i++) begin
            if (in_ready === 1'b1) hs++;
            step(1'b1, w[i], 1'b0, 1'b0);
        end
        idle();
        n_checks++;
        if (hs != 3 || fill_level !== (FILT ? 7'd2 : 7'd3)) begin
            n_fail++;
            $display("FAIL filter_count: got handshakes=%0d fill=%0d, want 3 and %0d",
                     hs, fill_level, FILT ? 2 : 3);
        end
        n_checks++;
        if (out_data !== (FILT ? w[1] : w[0])) begin
            n_fail++;
            $display("FAIL filter_head: got %h, want %h", out_data, FILT ? w[1] : w[0]);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int errs = 0;
        int first_bad = -1;
        for (int i = 0; i < 2000; i++) begin
            if (in_ready !== (model_q.size() != DEPTH) ||
                out_valid !== (model_q.size() != 0) ||
                fill_level !== 7'(model_q.size()) ||
                (model_q.size() != 0 && out_data !== model_q[0])) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
            step(1'($urandom_range(3) != 0),
                 mk(1'($urandom_range(7) == 0), $urandom_range(127), $urandom_range(127),
                    ($urandom_range(3) == 0) ? 0 : $urandom_range(3)),
                 1'($urandom_range(2) == 0), 1'($urandom_range(199) == 0));
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL random_traffic: got %0d mismatching cycles (first at %0d), want 0",
                     errs, first_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_clear();
        test_reset_mid();
        test_filter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_output_spike_fifo.md
# snn_output_spike_fifo

- Buffers packed output spike vectors (timestep flag, x, y, per-channel spikes) from the pooling/threshold stage until the downstream consumer accepts them.
- Sits directly downstream of the stage that builds output vectors with `create_output_spike_vector`.
- Provides valid/ready on both sides, an occupancy count and a synchronous flush.
- Can optionally discard vectors that carry no spikes and no timestep marker.

## Interface
Parameters:
- `DEPTH`, 64: number of entries; must be a power of two and at least 2.
- `DATA_WIDTH`, `OUTPUT_FIFO_DATA_WIDTH` (17): packed `output_vector_t` width.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous flush.
- `in_valid`, in, 1: upstream vector present.
- `in_ready`, out, 1: FIFO can accept a vector.
- `in_data`, in, `DATA_WIDTH`: packed `output_vector_t`. Bit 16 is timestep, [15:9] is x, [8:2] is y, [1:0] is spikes.
- `out_valid`, out, 1: head entry present.
- `out_ready`, in, 1: downstream accepts the head entry.
- `out_data`, out, `DATA_WIDTH`: head entry.
- `fill_level`, out, `$clog2(DEPTH)+1`: number of stored entries.

## Operation
- Circular buffer: register array `mem[DEPTH]`, pointers `wr_ptr` and `rd_ptr` of `$clog2(DEPTH)` bits, plus `count`.
- Pointers wrap from DEPTH-1 to 0 naturally; no special case.
- Accept: `in_valid && in_ready` stores `in_data` at `wr_ptr`, increments `wr_ptr`, `count++`.
- Pop: `out_valid && out_ready` increments `rd_ptr`, `count--`.
- Accept and pop in the same cycle: both pointers advance and `count` is unchanged.
- `in_ready = (count != DEPTH)`.
  - When full, no entry is accepted even if a pop happens in the same cycle (no write-through on full).
- `out_valid = (count != 0)`. `out_data = mem[rd_ptr]`, a combinational read of a registered array (first-word-fall-through).
- Empty FIFO with `in_valid`: the data is not visible on `out_data` until the next cycle (no bypass).
- `fill_level = count`.
- `clear` has priority over accept and pop in that cycle:
  - pointers and `count` go to 0;
  - the incoming vector is discarded;
  - `mem` contents are not cleared.
- Reset (`rst_n` low, at any time, including mid-transfer): pointers and `count` go to 0 immediately.
  - Outputs during reset: `in_ready`=1, `out_valid`=0, `fill_level`=0.
  - `out_data` during reset is don't-care. The bench only checks it when `out_valid`=1.
- `out_data` must be held stable while `out_valid && !out_ready`.
- Ordering is strict FIFO. Timestep markers (bit 16 = 1) never reorder relative to spike vectors.

## Timing
- Write-to-read latency: 1 cycle. Data accepted at edge N gives `out_valid`=1 after edge N.
- Sustained throughput: 1 vector per cycle in each direction when neither side stalls.
- `in_ready` and `out_valid` depend only on registered state (no combinational path from `in_valid`/`out_ready`).
- After `clear` or reset release: `in_ready`=1 on the first cycle.

## Configuration
- Macro: `SNN_OUTPUT_ZERO_FILTER_EN`.
- Defined: a vector with spikes == '0 and timestep == 0 is a zero vector.
  - It is consumed (`in_ready` handshake completes normally) but not stored.
  - `wr_ptr` and `count` are unchanged.
  - Vectors with any spike set, or with timestep = 1, are always stored.
- Not defined: every accepted vector is stored unchanged.

## Structure
- Add to the shared interfaces package:
  - `OUTPUT_FIFO_DATA_WIDTH`, `output_vector_t`, `pack_output_vector` (already there);
  - `DEFAULT_OUTPUT_FIFO_DEPTH` = 64;
  - helper function `is_zero_spike_vector(output_vector_t)`, used by the filter.
- No sub-module: storage, pointers and handshake stay in one module.

## Test plan
- Single write then read:
  - Stimulus: push x=5, y=3, spikes=2'b01, ts=0 into an empty FIFO, `out_ready`=0.
  - Response: `out_valid`=1 one cycle later with the same 17-bit word, `fill_level`=1. Raising `out_ready` gives `fill_level`=0 next cycle.
- Fill and stall:
  - Stimulus: push 64 distinct words with `out_ready`=0.
  - Response: `in_ready`=0 at `fill_level`=64. A 65th `in_valid` is not accepted. Draining returns all 64 words in order.
- Simultaneous push/pop:
  - Stimulus: with `fill_level`=10, hold `in_valid` and `out_ready` high for 100 cycles.
  - Response: `fill_level` stays 10, order preserved, pointers wrap without error.
- Clear priority:
  - Stimulus: with `fill_level`=7, assert `clear` together with `in_valid` and `out_ready`.
  - Response: next cycle `fill_level`=0, `out_valid`=0. The pushed word never appears.
- Reset mid-operation:
  - Stimulus: drop `rst_n` while `out_valid`=1 and `fill_level`=20.
  - Response: immediately `out_valid`=0, `fill_level`=0, `in_ready`=1.
- Filter (macro defined):
  - Stimulus: push spikes=0/ts=0, spikes=0/ts=1, spikes=2'b10/ts=0.
  - Response: all three handshakes complete. Only the last two are stored (`fill_level`=2). Without the macro, `fill_level`=3.
